voice_mixer_i2s_tx: RTL and testbench

- Consumes the per-voice subsample stream from the synthesis core: 16 subsamples per sample frame, with a sample-ready strobe on the last one.
- Sums the 16 subsamples into one mono sample, scales and saturates it, and buffers it in a small FIFO.
- Serialises the buffered samples to an external DAC over I2S, sending the same sample on both channels.
- Sits between the core output and the board-level DAC pins.

---
 rtl/voice_mixer_i2s_tx_pkg.sv | 20 ++
 rtl/voice_mixer_i2s_tx_sample_fifo.sv | 63 ++++++
 rtl/voice_mixer_i2s_tx.sv | 152 +++++++++++++++
 tb/tb_voice_mixer_i2s_tx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_mixer_i2s_tx_pkg.sv
// Shared types and helpers for the voice mixer / I2S transmitter.
package voice_mixer_i2s_tx_pkg;

    localparam int SAMPLE_W       = 16;
    localparam int I2S_FRAME_BITS = 32;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Clamp a wide signed value into the signed 16-bit sample range.
    function automatic sample_t sat16(input logic signed [31:0] value);
        if (value > 32'sd32767) begin
            return 16'sh7FFF;
        end else if (value < -32'sd32768) begin
            return 16'sh8000;
        end else begin
            return value[SAMPLE_W-1:0];
        end
    endfunction

endpackage

// File: rtl/voice_mixer_i2s_tx_sample_fifo.sv
// Synchronous sample FIFO with occupancy output.
// A pop frees its slot in the same cycle, so push+pop on a full FIFO both succeed.
module voice_mixer_i2s_tx_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_fire;
    logic             push_fire;

    assign full      = (level == LVL_W'(DEPTH));
    assign empty     = (level == '0);
    assign pop_fire  = pop && !empty;
    assign push_fire = push && (!full || pop_fire);
    assign pop_data  = mem[rd_ptr];

    // Sample storage written on an accepted push.
    // NOTE: the array has no reset; level decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push_fire, pop_fire})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/voice_mixer_i2s_tx.sv
// Mixes per-voice subsamples into one mono sample per frame, buffers the
// result and streams it to an I2S DAC on both channels.
module voice_mixer_i2s_tx
    import voice_mixer_i2s_tx_pkg::*;
#(
    parameter int NUM_VOICES   = 16,
    parameter int OUTPUT_SHIFT = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int BCLK_DIV     = 8
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset_n,
    input  logic [SAMPLE_W-1:0]           i_Subsample,
    input  logic                          i_SubsampleValid,
    input  logic                          i_SampleValid,
    input  logic                          i_ClearStatus,
    output logic                          o_Bclk,
    output logic                          o_Lrclk,
    output logic                          o_Sdata,
    output logic                          o_Overflow,
    output logic                          o_Underflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_FifoLevel
);

    localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES);
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W = $clog2(I2S_FRAME_BITS);
    localparam int SEL_W = $clog2(SAMPLE_W);

    // Accumulator and mixed-sample path.
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shifted;
    sample_t                 mixed;
    logic                    push;
    sample_t                 push_data;

    // Serialiser state.
    logic [DIV_W-1:0]        div_cnt;
    logic                    div_done;
    logic                    bclk_fall;
    logic [BIT_W-1:0]        bit_idx;
    logic [BIT_W-1:0]        next_bit;
    logic [SEL_W-1:0]        sel;
    sample_t                 frame;

    // FIFO interface.
    logic                    pop;
    logic                    pop_ok;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [SAMPLE_W-1:0]     fifo_head;

    // Running sum with the incoming subsample, then scale and clamp to 16 bits.
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        sum     = acc + {{(ACC_W - SAMPLE_W){i_Subsample[SAMPLE_W-1]}}, i_Subsample};
        shifted = sum >>> OUTPUT_SHIFT;
        mixed   = sat16({{(32 - ACC_W){shifted[ACC_W-1]}}, shifted});
    end

    // Accumulate subsamples; on frame end hand the mixed sample to the FIFO next cycle.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            acc       <= '0;
            push      <= 1'b0;
            push_data <= '0;
        end else begin
            push <= i_SubsampleValid && i_SampleValid;
            if (i_SubsampleValid) begin
                if (i_SampleValid) begin
                    acc       <= '0;
                    push_data <= mixed;
                end else begin
                    acc <= sum;
                end
            end
        end
    end

    voice_mixer_i2s_tx_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk       (i_Clock),
        .rst_n     (i_Reset_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (fifo_head),
        .level     (o_FifoLevel),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Frame of 32 bits: the 5-bit index wraps 31 -> 0 on its own.
    // Bit b carries frame bit (16 - b) mod 16, which also gives the previous
    // frame's LSB at b = 0 because the frame register updates on that same edge.
    assign div_done  = (div_cnt == DIV_W'(BCLK_DIV - 1));
    assign bclk_fall = div_done && o_Bclk;
    assign next_bit  = bit_idx + 1'b1;
    assign sel       = SEL_W'(I2S_FRAME_BITS / 2 - int'(next_bit));
    assign pop       = bclk_fall && (next_bit == '0);
    assign pop_ok    = pop && !fifo_empty;

    // Bit-clock divider, word select and serial data, all stepped on BCLK falling edges.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            div_cnt <= '0;
            o_Bclk  <= 1'b0;
            bit_idx <= BIT_W'(I2S_FRAME_BITS - 1);
            o_Lrclk <= 1'b0;
            o_Sdata <= 1'b0;
            frame   <= '0;
        end else begin
            if (div_done) begin
                div_cnt <= '0;
                o_Bclk  <= ~o_Bclk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (bclk_fall) begin
                bit_idx <= next_bit;
                o_Lrclk <= (next_bit >= BIT_W'(I2S_FRAME_BITS / 2));
                o_Sdata <= frame[sel];
            end
            if (pop_ok) begin
                frame <= fifo_head;
            end
        end
    end

    // Sticky status flags; a new event in the clear cycle keeps the flag set.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_Overflow  <= 1'b0;
            o_Underflow <= 1'b0;
        end else begin
            if (push && fifo_full && !pop_ok) begin
                o_Overflow <= 1'b1;
            end else if (i_ClearStatus) begin
                o_Overflow <= 1'b0;
            end
            if (pop && fifo_empty) begin
                o_Underflow <= 1'b1;
            end else if (i_ClearStatus) begin
                o_Underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_voice_mixer_i2s_tx.sv
// Directed bench for voice_mixer_i2s_tx: mixing, saturation, FIFO flags and I2S framing.
module tb_voice_mixer_i2s_tx;

    logic        clk;
    logic        rst_n;
    logic [15:0] subsample;
    logic        subsample_valid;
    logic        sample_valid;
    logic        clear_status;

    logic        bclk, lrclk, sdata, ovf, ufl;
    logic [2:0]  level;
    logic        bclk8, lrclk8, sdata8, ovf8, ufl8;
    logic [2:0]  level8;

    int checks = 0;
    int errors = 0;
    int cycle;

    logic [31:0] sd_word;
    logic [31:0] lr_word;

    voice_mixer_i2s_tx #(
        .BCLK_DIV (1)
    ) dut (
        .i_Clock          (clk),
        .i_Reset_n        (rst_n),
        .i_Subsample      (subsample),
        .i_SubsampleValid (subsample_valid),
        .i_SampleValid    (sample_valid),
        .i_ClearStatus    (clear_status),
        .o_Bclk           (bclk),
        .o_Lrclk          (lrclk),
        .o_Sdata          (sdata),
        .o_Overflow       (ovf),
        .o_Underflow      (ufl),
        .o_FifoLevel      (level)
    );

    voice_mixer_i2s_tx #(
        .BCLK_DIV (8)
    ) dut8 (
        .i_Clock          (clk),
        .i_Reset_n        (rst_n),
        .i_Subsample      (subsample),
        .i_SubsampleValid (subsample_valid),
        .i_SampleValid    (sample_valid),
        .i_ClearStatus    (clear_status),
        .o_Bclk           (bclk8),
        .o_Lrclk          (lrclk8),
        .o_Sdata          (sdata8),
        .o_Overflow       (ovf8),
        .o_Underflow      (ufl8),
        .o_FifoLevel      (level8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cycle <= 0;
        else        cycle <= cycle + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycle(input int n);
        while (cycle < n) tick();
    endtask

    // Drives count subsamples of one value, the last flagged as frame end.
    task automatic send_frame(input int value, input int count);
        for (int i = 0; i < count; i++) begin
            subsample       = 16'(value);
            subsample_valid = 1'b1;
            sample_valid    = (i == count - 1);
            tick();
        end
        subsample_valid = 1'b0;
        sample_valid    = 1'b0;
        subsample       = '0;
    endtask

    // Samples one full I2S frame starting at b = 0; returns at the next b = 0.
    task automatic capture(output logic [31:0] sd, output logic [31:0] lr);
        sd = '0;
        lr = '0;
        for (int i = 0; i < 32; i++) begin
            sd = {sd[30:0], sdata};
            lr = {lr[30:0], lrclk};
            tick();
            tick();
        end
    endtask

    // Serial line seen from b = 0: previous LSB, left word MSB..LSB, right word MSB..bit 1.
    function automatic logic [31:0] exp_word(input logic prev_lsb, input logic [15:0] w);
        return {prev_lsb, w, w[15:1]};
    endfunction

    initial begin
        rst_n           = 1'b0;
        subsample       = '0;
        subsample_valid = 1'b0;
        sample_valid    = 1'b0;
        clear_status    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_bclk",  32'(bclk),  0);
        check("reset_lrclk", 32'(lrclk), 0);
        check("reset_sdata", 32'(sdata), 0);
        check("reset_ovf",   32'(ovf),   0);
        check("reset_ufl",   32'(ufl),   0);
        check("reset_level", 32'(level), 0);
        rst_n = 1'b1;

        tick();
        check("bclk_c1", 32'(bclk), 1);
        check("ufl_c1",  32'(ufl),  0);
        tick();
        check("bclk_c2",  32'(bclk),  0);
        check("lrclk_b0", 32'(lrclk), 0);
        check("ufl_first_b0", 32'(ufl), 1);
        check("level_first_b0", 32'(level), 0);

        fork
            capture(sd_word, lr_word);
            begin
                clear_status = 1'b1;
                tick();
                clear_status = 1'b0;
                check("ufl_cleared", 32'(ufl),  0);
                check("bclk_c3",     32'(bclk), 1);
                send_frame(1000, 16);
                tick();
                check("level_after_4000", 32'(level), 1);
            end
            begin
                wait_cycle(7);
                check("div8_bclk_c7", 32'(bclk8), 0);
                wait_cycle(8);
                check("div8_bclk_c8", 32'(bclk8), 1);
                wait_cycle(15);
                check("div8_bclk_c15", 32'(bclk8), 1);
                check("div8_ufl_c15",  32'(ufl8),  0);
                wait_cycle(16);
                check("div8_bclk_c16",  32'(bclk8),  0);
                check("div8_ufl_c16",   32'(ufl8),   1);
                check("div8_lrclk_c16", 32'(lrclk8), 0);
                check("div8_sdata_c16", 32'(sdata8), 0);
                check("div8_ovf_c16",   32'(ovf8),   0);
                check("div8_level_c16", 32'(level8), 0);
            end
        join
        check("frame0_sdata", sd_word, 32'h0000_0000);
        check("frame0_lrclk", lr_word, 32'h0000_FFFF);
        check("pop_4000_level", 32'(level), 0);
        check("pop_4000_ufl",   32'(ufl),   0);

        fork
            capture(sd_word, lr_word);
            begin
                send_frame(-32767, 4);
                tick();
                check("level_after_8001", 32'(level), 1);
            end
        join
        check("frame_4000_sdata", sd_word, exp_word(1'b0, 16'h0FA0));
        check("frame_4000_lrclk", lr_word, 32'h0000_FFFF);
        check("pop_8001_ufl", 32'(ufl), 0);

        capture(sd_word, lr_word);
        check("frame_8001_sdata", sd_word, exp_word(1'b0, 16'h8001));
        check("empty_b0_ufl",   32'(ufl),   1);
        check("empty_b0_sdata", 32'(sdata), 1);

        fork
            capture(sd_word, lr_word);
            begin
                clear_status = 1'b1;
                tick();
                clear_status = 1'b0;
                check("ufl_cleared_again", 32'(ufl), 0);
                send_frame(30000, 16);
                send_frame(-32768, 16);
                tick();
                check("level_two_sat", 32'(level), 2);
            end
        join
        check("frame_held_sdata", sd_word, exp_word(1'b1, 16'h8001));
        check("pop_pos_sat_level", 32'(level), 1);

        capture(sd_word, lr_word);
        check("frame_pos_sat_sdata", sd_word, exp_word(1'b1, 16'h7FFF));
        check("pop_neg_sat_level", 32'(level), 0);

        fork
            capture(sd_word, lr_word);
            begin
                send_frame(-4, 1);
                send_frame(-4, 1);
                send_frame(12, 1);
                send_frame(16, 1);
                send_frame(20, 1);
                tick();
                check("ovf_set",        32'(ovf),   1);
                check("ovf_full_level", 32'(level), 4);
                clear_status = 1'b1;
                tick();
                clear_status = 1'b0;
                check("ovf_cleared", 32'(ovf), 0);
                wait_cycle(384);
                send_frame(24, 1);
            end
        join
        check("frame_neg_sat_sdata", sd_word, exp_word(1'b1, 16'h8000));
        check("full_push_pop_level", 32'(level), 4);
        check("full_push_pop_ovf",   32'(ovf),   0);
        check("full_push_pop_ufl",   32'(ufl),   0);

        capture(sd_word, lr_word);
        check("frame_ffff_sdata", sd_word, exp_word(1'b0, 16'hFFFF));

        repeat (41) tick();
        check("mid_word_bclk",  32'(bclk),  1);
        check("mid_word_lrclk", 32'(lrclk), 1);
        check("mid_word_sdata", 32'(sdata), 1);
        check("mid_word_level", 32'(level), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_bclk",  32'(bclk),  0);
        check("async_rst_lrclk", 32'(lrclk), 0);
        check("async_rst_sdata", 32'(sdata), 0);
        check("async_rst_level", 32'(level), 0);
        check("async_rst_ovf",   32'(ovf),   0);
        check("async_rst_ufl",   32'(ufl),   0);

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        check("restart_bclk", 32'(bclk), 0);
        check("restart_ufl",  32'(ufl),  1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
